// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio source and the I2S transmitter.
// Valid/ready: a pair moves on any clk edge where smpl_vld and smpl_rdy are
// both high; the source holds lft_in/rht_in stable while smpl_vld waits for
// smpl_rdy, and smpl_rdy never depends on smpl_vld.
interface i2s_tx_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] lft_in;
    logic signed [DATA_W-1:0] rht_in;
    logic                     smpl_vld;
    logic                     smpl_rdy;

    modport master (
        output lft_in,
        output rht_in,
        output smpl_vld,
        input  smpl_rdy
    );

    modport slave (
        input  lft_in,
        input  rht_in,
        input  smpl_vld,
        output smpl_rdy
    );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: derives MCLK/SCLK/LRCLK from one 11-bit frame counter,
// buffers one stereo sample pair and shifts it out MSB-first, one SCLK late.
// Optional build macro I2S_TX_MUTE_ON_UNDRN_EN: an underrun frame sends
// silence instead of repeating the previous sample pair.
module i2s_tx #(
    parameter int DATA_W = 16
) (
    input  logic   clk,
    input  logic   rst,
    i2s_tx_if.slave smpl,
    output logic   MCLK,
    output logic   SCLK,
    output logic   LRCLK,
    output logic   SDin,
    output logic   frm_strt,
    output logic   undrn
);

    logic [10:0]        cnt;
    logic [10:0]        cnt_n;
    logic               load;
    logic               xfer;
    logic               full;
    logic               loaded_q;
    logic [DATA_W-1:0]  buf_l;
    logic [DATA_W-1:0]  buf_r;
    logic [DATA_W-1:0]  sh_l;
    logic [DATA_W-1:0]  sh_r;
    logic [23:0]        word;
    logic [4:0]         slot_n;
    logic [4:0]         bit_idx;
    logic               sd_nxt;
    logic               sd_q;

    // Last cycle of the frame: the buffered pair moves into the shifters.
    assign load  = (cnt == 11'd2047);
    assign cnt_n = cnt + 11'd1;

    // Ready never waits on valid; at the frame boundary the buffer is
    // drained in the same edge, so a new pair can always be taken there.
    assign smpl.smpl_rdy = ~full | load;
    assign xfer          = smpl.smpl_vld & smpl.smpl_rdy;

    // Codec clocks are straight counter bits so their phases stay locked.
    assign MCLK  = cnt[1];
    assign SCLK  = cnt[4];
    assign LRCLK = cnt[10];
    assign SDin  = sd_q;

    // Gated by rst so that reset cycles show no frame start, while the
    // first cycle after release (cnt still 0) does.
    assign frm_strt = (cnt == 11'd0) & ~rst;
    // loaded_q is 0 after reset, so the first frame reports an underrun.
    assign undrn    = frm_strt & ~loaded_q;

    // Free-running frame counter; wraps 2047 -> 0 by width.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

    // Holding buffer, full flag and channel shifters.
    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            loaded_q <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
            sh_l     <= '0;
            sh_r     <= '0;
        end else begin
            if (xfer) begin
                buf_l <= smpl.lft_in;
                buf_r <= smpl.rht_in;
            end
            if (load) begin
                loaded_q <= full;
                if (full) begin
                    sh_l <= buf_l;
                    sh_r <= buf_r;
                end
`ifdef I2S_TX_MUTE_ON_UNDRN_EN
                else begin
                    sh_l <= '0;
                    sh_r <= '0;
                end
`endif
                // A pair accepted on the load edge refills the buffer.
                full <= xfer;
            end else if (xfer) begin
                full <= 1'b1;
            end
        end
    end

    // Pick the bit for the slot about to start: slot 0 is the I2S one-bit
    // delay, slots 1..24 carry the left-justified word, the rest pad with 0.
    always_comb begin
        word    = '0;
        slot_n  = cnt_n[9:5];
        bit_idx = 5'd24 - slot_n;
        sd_nxt  = 1'b0;
        word[23 -: DATA_W] = cnt_n[10] ? sh_r : sh_l;
        if (slot_n >= 5'd1 && slot_n <= 5'd24) begin
            sd_nxt = word[bit_idx];
        end
    end

    // SDin changes only on the edge where SCLK falls (cnt[4:0] 31 -> 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_q <= 1'b0;
        end else if (cnt[4:0] == 5'd31) begin
            sd_q <= sd_nxt;
        end
    end

endmodule
